bcd_counter_n: RTL
==================

# bcd_counter_n

Parametrised multi-digit synchronous BCD counter with cascaded decade carry, parallel load, terminal-count and wrap flags. It is the general counting primitive for timer, display and event-count datapaths. It replaces single-decade counters chained by hand. An optional down-count mode is selected at compile time.

## Interface

Parameters:
- DIGITS, default 4: number of BCD decades; legal range 1..8.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high. Highest priority.
- en  input  1  count enable; one step per clock while high.
- load  input  1  parallel load strobe; priority over en.
- load_val  input  4*DIGITS  BCD load value; digit 0 in bits [3:0].
- up_dn  input  1  direction: 1 = up, 0 = down. Present only with BCD_CNT_DOWN_EN.
- count  output  4*DIGITS  current BCD value, registered; digit 0 is least significant.
- co  output  1  registered terminal flag: high while count equals the terminal value for the current direction.
- wrap  output  1  registered one-cycle pulse: high in the cycle count shows the value just wrapped to.

## Operation

- Per-edge priority is rst > load > en > hold.
- rst: count = 0; wrap = 0. co = 0 when counting up, 1 when counting down (0…0 is the down terminal value).
- load:
  - count takes load_val digit by digit.
  - Any nibble greater than 9 is clamped to 9.
  - wrap = 0.
- Up step:
  - Digit i increments when en = 1 and every digit below it equals 9.
  - A digit equal to 9 that steps goes to 0.
  - All-9s steps to all-0s and sets wrap = 1 for one cycle.
- Down step:
  - Digit i decrements when en = 1 and every digit below it equals 0.
  - A digit equal to 0 that steps goes to 9.
  - All-0s steps to all-9s and sets wrap = 1 for one cycle.
- Hold (en = 0, load = 0): count unchanged; wrap = 0.
- co is recomputed every clock from the next count and the up_dn sampled at that edge, whether or not the counter steps.
  - Without the macro, co = 1 exactly when count is all 9s.
- Digit arithmetic is 4-bit unsigned; no binary carry propagates between nibbles. Carry is purely the decade enable chain.
- Digits never hold values above 9.

## Timing

- Load-to-count latency is 1 cycle. Enable-to-count latency is 1 cycle.
- co and wrap are valid in the same cycle as the count they describe.
- Carry ripple across all digits completes within one cycle. There is no multi-cycle carry.
- Direction change with en = 0: co reflects the new direction after the next edge, i.e. it lags by one cycle.
- load and en both high: load wins; no step occurs that cycle.
- rst asserted mid-count: next cycle count = 0 regardless of load or en.
- DIGITS = 1 behaves as a single decade 0..9 with co high at 9.

## Configuration

- BCD_CNT_DOWN_EN defined:
  - up_dn port exists and selects direction every cycle.
  - Down stepping, down terminal (all 0s) and down wrap (all 0s to all 9s) are implemented.
- BCD_CNT_DOWN_EN undefined:
  - up_dn port is absent.
  - The counter is up-only; co is high only at all 9s; reset value of co is 0.
  - No down logic is synthesised.

## Structure

- Package bcd_pkg holds:
  - DIGIT_W = 4;
  - BCD_MAX = 4'd9;
  - BCD_MIN = 4'd0;
  - a function clamping a nibble to 0..9.
- Sub-module bcd_digit, instantiated DIGITS times.
  - Inputs: clk, rst, step, dir, load, load_nibble.
  - Outputs: the digit register, plus combinational is_max and is_min flags used to build the enable chain.
- The top level owns:
  - the prefix-AND enable chain;
  - the co register;
  - the wrap register.

## Test plan

- Reset, DIGITS = 4, en = 1 for 10000 cycles:
  - count runs 0000 to 9999;
  - co high only at 9999;
  - next cycle count = 0000 and wrap = 1 for exactly one cycle.
- load = 1 with load_val = 0x1234 and en = 1 in the same cycle: next count = 0x1234; the following cycle (en = 1, load = 0) gives 0x1235.
- Load 0x00AF: count = 0x0099; one en cycle gives 0x0100 with digit 0 and digit 1 both rolling over.
- Hold at 0x0509 with en = 0 for 5 cycles: count stays 0x0509, co = 0, wrap = 0.
- With BCD_CNT_DOWN_EN, up_dn = 0 from reset:
  - co = 1 at 0000;
  - one en cycle gives 9999 with wrap = 1;
  - the next en cycle gives 9998.
- rst asserted together with load = 1 (load_val = 0x4321) and en = 1 at count 0x0777: next count = 0x0000, co = 0 (up mode), wrap = 0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD counter datapath.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

  // Any non-decimal nibble saturates to 9 so a digit can never leave 0..9.
  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade register: load, step up/down with decimal rollover.
// Down stepping exists only when BCD_CNT_DOWN_EN is defined.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               dir,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_nibble,
  output logic [DIGIT_W-1:0] digit,
  output logic               is_max,
  output logic               is_min
);

  assign is_max = (digit == BCD_MAX);
  assign is_min = (digit == BCD_MIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= bcd_clamp(load_nibble);
    end else if (step && dir) begin
      digit <= is_max ? BCD_MIN : digit + 4'd1;
`ifdef BCD_CNT_DOWN_EN
    end else if (step) begin
      digit <= is_min ? BCD_MAX : digit - 4'd1;
`endif
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-decade BCD counter: prefix-AND decade enable chain, terminal (co) and wrap flags.
// Optional down counting via the BCD_CNT_DOWN_EN macro (adds the up_dn port).
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
`ifdef BCD_CNT_DOWN_EN
  input  logic                      up_dn,
`endif
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                      co,
  output logic                      wrap
);

  logic              dir;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] up_chain;
  logic [DIGITS-1:0] is_max;
  logic [DIGITS-1:0] is_min;
  logic              all_max;
  logic              all_min;
  logic              upper_max;
  logic              load_max;
  logic              nxt_max;
  logic              co_d;
  logic              wrap_d;

  assign all_max = &is_max;
  assign all_min = &is_min;

`ifdef BCD_CNT_DOWN_EN
  logic [DIGITS-1:0] dn_chain;
  logic              upper_min;
  logic              load_min;
  logic              nxt_min;
  assign dir  = up_dn;
  assign step = dir ? up_chain : dn_chain;
`else
  logic unused_min;
  assign dir        = 1'b1;
  assign step       = up_chain;
  assign unused_min = all_min;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    // Digit g steps only when every lower digit sits at its rollover value.
    if (g == 0) begin : g_lsd
      assign up_chain[g] = en;
`ifdef BCD_CNT_DOWN_EN
      assign dn_chain[g] = en;
`endif
    end else begin : g_upper
      assign up_chain[g] = en & (&is_max[g-1:0]);
`ifdef BCD_CNT_DOWN_EN
      assign dn_chain[g] = en & (&is_min[g-1:0]);
`endif
    end

    bcd_digit u_digit (
      .clk         (clk),
      .rst         (rst),
      .step        (step[g]),
      .dir         (dir),
      .load        (load),
      .load_nibble (load_val[g*DIGIT_W +: DIGIT_W]),
      .digit       (count[g*DIGIT_W +: DIGIT_W]),
      .is_max      (is_max[g]),
      .is_min      (is_min[g])
    );
  end

  // co is registered from the value count will hold after this edge.
  always_comb begin
    upper_max = 1'b1;
    for (int i = 1; i < DIGITS; i++) upper_max &= is_max[i];
    load_max = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      load_max &= (bcd_clamp(load_val[i*DIGIT_W +: DIGIT_W]) == BCD_MAX);

    if (load)           nxt_max = load_max;
    else if (en && dir) nxt_max = upper_max && (count[DIGIT_W-1:0] == BCD_MAX - 4'd1);
`ifdef BCD_CNT_DOWN_EN
    else if (en)        nxt_max = all_min;
`endif
    else                nxt_max = all_max;

`ifdef BCD_CNT_DOWN_EN
    upper_min = 1'b1;
    for (int i = 1; i < DIGITS; i++) upper_min &= is_min[i];
    load_min = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      load_min &= (load_val[i*DIGIT_W +: DIGIT_W] == BCD_MIN);

    if (load)           nxt_min = load_min;
    else if (en && dir) nxt_min = all_max;
    else if (en)        nxt_min = upper_min && (count[DIGIT_W-1:0] == BCD_MIN + 4'd1);
    else                nxt_min = all_min;

    co_d = dir ? nxt_max : nxt_min;
`else
    co_d = nxt_max;
`endif

    wrap_d = en && !load && (dir ? all_max : all_min);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      co   <= !dir;
      wrap <= 1'b0;
    end else begin
      co   <= co_d;
      wrap <= wrap_d;
    end
  end

endmodule
